npc_mem_arbiter: RTL and testbench

//   Shares one single-ported memory bus between the IF fetch port and the MEM data port of the npc core.

---
 rtl/npc_mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_npc_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// NpcMemArbiter (module npc_mem_arbiter)
//
// Shares one single-ported memory bus between the IF fetch port and the MEM
// data port of the npc core. Data accesses win over fetches because they belong
// to the instruction already in flight. A granted access is registered onto the
// bus and held there until the memory acknowledges it. The result then goes
// back to the requester with a one-cycle valid pulse. A wait-cycle watchdog
// aborts any access that never completes and raises a sticky error flag.
//
// Ports
//   clk, rst      clock and asynchronous active-high reset
//   if_req_i      fetch request, held until if_valid_o
//   if_addr_i     fetch address
//   if_inst_o     fetched instruction (registered)
//   if_valid_o    one-cycle fetch-complete pulse
//   d_req_i       data request, held until d_valid_o
//   d_we_i        1 = write, 0 = read
//   d_addr_i      data address
//   d_wdata_i     write data
//   d_wmask_i     byte write enables
//   d_rdata_o     read data (registered)
//   d_valid_o     one-cycle data-complete pulse
//   hold_flag_o   stall request to the core
//   bus_req_o     bus transaction valid
//   bus_we_o      bus write
//   bus_addr_o    bus address
//   bus_wdata_o   bus write data
//   bus_wmask_o   bus byte enables
//   bus_rdata_i   bus read data, valid with bus_ack_i
//   bus_ack_i     bus transaction complete
//   timeout_o     sticky watchdog error flag
//
// DATA_W must be 32 or 64. MAX_WAIT must be at least 1.
// -----------------------------------------------------------------------------
module npc_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int INST_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [INST_W-1:0]   if_inst_o,
  output logic                if_valid_o,

  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_wmask_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_valid_o,

  output logic                hold_flag_o,

  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_wmask_o,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  input  logic                bus_ack_i,

  output logic                timeout_o
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [CNT_W-1:0]  WAIT_LIMIT = CNT_W'(MAX_WAIT);
  localparam logic [INST_W-1:0] NOP_INST   = INST_W'(32'h0000_0013);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_D,
    BUSY_I,
    DONE_D,
    DONE_I
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [INST_W-1:0] fetch_word;
  logic              wait_expired;

  // Pick the instruction word out of the bus beat. On a 64-bit bus, address
  // bit 2 of the fetch (still held on bus_addr_o) selects the upper or lower word.
  generate
    if (DATA_W == 64) begin : g_wide_bus
      assign fetch_word = bus_addr_o[2] ? bus_rdata_i[32 +: INST_W]
                                        : bus_rdata_i[INST_W-1:0];
    end else begin : g_narrow_bus
      assign fetch_word = bus_rdata_i[INST_W-1:0];
    end
  endgenerate

  // The watchdog fires on the (MAX_WAIT+1)-th BUSY cycle without an ack.
  // Because it fires at the limit, the counter never needs to wrap.
  assign wait_expired = (wait_cnt == WAIT_LIMIT);

  // Stall while a request is pending. The stall drops in the DONE cycle, when
  // the matching valid pulse is up.
  assign hold_flag_o = (d_req_i & ~d_valid_o) | (if_req_i & ~if_valid_o);

  // Arbitration FSM. It owns every registered output: the bus registers, the
  // results returned to each requester, the valid pulses, and the watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_wmask_o <= '0;
      if_inst_o   <= '0;
      if_valid_o  <= 1'b0;
      d_rdata_o   <= '0;
      d_valid_o   <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (d_req_i) begin
            state       <= BUSY_D;
            bus_req_o   <= 1'b1;
            bus_we_o    <= d_we_i;
            bus_addr_o  <= d_addr_i;
            bus_wdata_o <= d_wdata_i;
            bus_wmask_o <= d_wmask_i;
          end else if (if_req_i) begin
            // A fetch is always a read with no byte enables.
            state       <= BUSY_I;
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= if_addr_i;
            bus_wdata_o <= '0;
            bus_wmask_o <= {MASK_W{1'b0}};
          end
        end

        BUSY_D: begin
          // An ack in the same cycle as the watchdog limit counts as a normal
          // completion, so the ack is checked first.
          if (bus_ack_i) begin
            state     <= DONE_D;
            bus_req_o <= 1'b0;
            d_valid_o <= 1'b1;
            if (!bus_we_o) begin
              d_rdata_o <= bus_rdata_i;
            end
          end else if (wait_expired) begin
            state     <= DONE_D;
            bus_req_o <= 1'b0;
            d_valid_o <= 1'b1;
            timeout_o <= 1'b1;
            if (!bus_we_o) begin
              d_rdata_o <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        BUSY_I: begin
          // An aborted fetch hands the core a NOP so that it can continue.
          if (bus_ack_i) begin
            state      <= DONE_I;
            bus_req_o  <= 1'b0;
            if_valid_o <= 1'b1;
            if_inst_o  <= fetch_word;
          end else if (wait_expired) begin
            state      <= DONE_I;
            bus_req_o  <= 1'b0;
            if_valid_o <= 1'b1;
            if_inst_o  <= NOP_INST;
            timeout_o  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        DONE_D: begin
          // Requests are ignored here. This gives the requester one cycle to
          // drop its request before the next grant.
          d_valid_o <= 1'b0;
          state     <= IDLE;
        end

        DONE_I: begin
          if_valid_o <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for npc_mem_arbiter. The bench plays both requesters and the memory.
// A fixed table of single transactions runs first. Hand-written sequences then
// cover arbitration, the watchdog and reset. Randomized transactions are checked
// against a transaction-level model of the results returned to the core.
// -----------------------------------------------------------------------------
module tb_npc_mem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 64;
  localparam int INST_W   = 32;
  localparam int MAX_WAIT = 15;
  localparam int MASK_W   = DATA_W / 8;

  logic                clk;
  logic                rst;
  logic                if_req_i;
  logic [ADDR_W-1:0]   if_addr_i;
  logic [INST_W-1:0]   if_inst_o;
  logic                if_valid_o;
  logic                d_req_i;
  logic                d_we_i;
  logic [ADDR_W-1:0]   d_addr_i;
  logic [DATA_W-1:0]   d_wdata_i;
  logic [MASK_W-1:0]   d_wmask_i;
  logic [DATA_W-1:0]   d_rdata_o;
  logic                d_valid_o;
  logic                hold_flag_o;
  logic                bus_req_o;
  logic                bus_we_o;
  logic [ADDR_W-1:0]   bus_addr_o;
  logic [DATA_W-1:0]   bus_wdata_o;
  logic [MASK_W-1:0]   bus_wmask_o;
  logic [DATA_W-1:0]   bus_rdata_i;
  logic                bus_ack_i;
  logic                timeout_o;

  int checks = 0;
  int errors = 0;

  // Model of what the core should currently see on the result ports.
  logic [DATA_W-1:0] m_d_rdata = '0;
  bit                m_timeout = 1'b0;

  typedef struct {
    bit                is_data;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
    int                delay;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  npc_mem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .INST_W  (INST_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_inst_o  (if_inst_o),
    .if_valid_o (if_valid_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_wmask_i  (d_wmask_i),
    .d_rdata_o  (d_rdata_o),
    .d_valid_o  (d_valid_o),
    .hold_flag_o(hold_flag_o),
    .bus_req_o  (bus_req_o),
    .bus_we_o   (bus_we_o),
    .bus_addr_o (bus_addr_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_wmask_o(bus_wmask_o),
    .bus_rdata_i(bus_rdata_i),
    .bus_ack_i  (bus_ack_i),
    .timeout_o  (timeout_o)
  );

  // Free-running clock with a 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit, so that a hung design cannot stall the run.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  // Advance to 1 ns after the next rising edge. Inputs are driven and outputs
  // sampled at this point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected instruction word for a fetch: address bit 2 picks the word.
  function automatic logic [63:0] fetchWord(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] rdata);
    return addr[2] ? {32'h0, rdata[63:32]} : {32'h0, rdata[31:0]};
  endfunction

  // One complete transaction, starting and ending with the arbiter in IDLE.
  // 'delay' is the number of BUSY cycles before the ack. A delay above MAX_WAIT
  // means the memory never acknowledges the access.
  task automatic applyStimulus(input bit is_data, input bit we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata, input logic [MASK_W-1:0] wmask,
                               input int delay, input logic [DATA_W-1:0] rdata,
                               input logic [DATA_W-1:0] exp_data, input bit exp_timeout);
    if (is_data) begin
      d_req_i = 1'b1; d_we_i = we; d_addr_i = addr; d_wdata_i = wdata; d_wmask_i = wmask;
    end else begin
      if_req_i = 1'b1; if_addr_i = addr;
    end
    #1;
    checkOutput("hold_on_request", hold_flag_o, 1);
    checkOutput("bus_req_idle", bus_req_o, 0);
    step();
    for (int b = 0; b <= MAX_WAIT; b++) begin
      checkOutput("bus_req_busy", bus_req_o, 1);
      checkOutput("bus_addr", bus_addr_o, addr);
      checkOutput("bus_we", bus_we_o, is_data ? we : 1'b0);
      checkOutput("bus_wmask", bus_wmask_o, is_data ? wmask : '0);
      if (is_data) checkOutput("bus_wdata", bus_wdata_o, wdata);
      if (b == 0) checkOutput("hold_busy", hold_flag_o, 1);
      if (b == delay) begin
        bus_ack_i = 1'b1; bus_rdata_i = rdata;
      end else begin
        bus_rdata_i = {$urandom, $urandom};
      end
      step();
      bus_ack_i = 1'b0;
      if (b == delay) break;
    end
    // DONE cycle
    checkOutput("bus_req_done", bus_req_o, 0);
    checkOutput("hold_done", hold_flag_o, 0);
    checkOutput("timeout_done", timeout_o, exp_timeout);
    if (is_data) begin
      checkOutput("d_valid_pulse", d_valid_o, 1);
      checkOutput("if_valid_quiet", if_valid_o, 0);
      checkOutput("d_rdata", d_rdata_o, exp_data);
    end else begin
      checkOutput("if_valid_pulse", if_valid_o, 1);
      checkOutput("d_valid_quiet", d_valid_o, 0);
      checkOutput("if_inst", if_inst_o, exp_data[31:0]);
    end
    d_req_i = 1'b0; if_req_i = 1'b0;
    step();
    checkOutput("d_valid_after", d_valid_o, 0);
    checkOutput("if_valid_after", if_valid_o, 0);
    checkOutput("bus_req_after", bus_req_o, 0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h8000_0004, 64'h0, 8'h00, 0,  64'h1111_2222_3333_4444, 64'h1111_2222};
    vecs[1] = '{1'b0, 1'b0, 32'h8000_0000, 64'h0, 8'h00, 1,  64'h1111_2222_3333_4444, 64'h3333_4444};
    vecs[2] = '{1'b1, 1'b0, 32'h8000_1000, 64'h0, 8'h00, 2,  64'hCAFE_F00D_1234_5678, 64'hCAFE_F00D_1234_5678};
    vecs[3] = '{1'b1, 1'b1, 32'h8000_1008, 64'hDEAD_BEEF, 8'h0F, 3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hCAFE_F00D_1234_5678};
    vecs[4] = '{1'b1, 1'b0, 32'h8000_2000, 64'h0, 8'h00, MAX_WAIT, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    vecs[5] = '{1'b0, 1'b0, 32'h8000_000C, 64'h0, 8'h00, MAX_WAIT, 64'hAAAA_5555_0000_0000, 64'hAAAA_5555};

    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_wmask_i = '0;
    bus_rdata_i = '0; bus_ack_i = 1'b0;

    // Reset state
    step();
    step();
    checkOutput("reset_bus_req", bus_req_o, 0);
    checkOutput("reset_d_valid", d_valid_o, 0);
    checkOutput("reset_if_valid", if_valid_o, 0);
    checkOutput("reset_if_inst", if_inst_o, 0);
    checkOutput("reset_d_rdata", d_rdata_o, 0);
    checkOutput("reset_timeout", timeout_o, 0);
    checkOutput("reset_hold", hold_flag_o, 0);
    rst = 1'b0;
    step();

    // Table of single transactions
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].is_data, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
                    vecs[i].delay, vecs[i].rdata, vecs[i].exp_data, 1'b0);
      if (vecs[i].is_data) m_d_rdata = vecs[i].exp_data;
    end

    // Simultaneous requests: the data access goes first, the fetch follows
    // after the DONE and IDLE bubble.
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h8000_1000;
    if_req_i = 1'b1; if_addr_i = 32'h8000_0008;
    step();
    checkOutput("both_first_addr", bus_addr_o, 32'h8000_1000);
    checkOutput("both_first_req", bus_req_o, 1);
    bus_ack_i = 1'b1; bus_rdata_i = 64'h5555_6666_7777_8888;
    step();
    bus_ack_i = 1'b0;
    checkOutput("both_d_valid", d_valid_o, 1);
    checkOutput("both_if_wait", if_valid_o, 0);
    checkOutput("both_d_rdata", d_rdata_o, 64'h5555_6666_7777_8888);
    checkOutput("both_hold_if", hold_flag_o, 1);
    m_d_rdata = 64'h5555_6666_7777_8888;
    d_req_i = 1'b0;
    step();
    checkOutput("both_bubble", bus_req_o, 0);
    step();
    checkOutput("both_if_grant", bus_req_o, 1);
    checkOutput("both_if_addr", bus_addr_o, 32'h8000_0008);
    bus_ack_i = 1'b1; bus_rdata_i = 64'h9999_AAAA_BBBB_CCCC;
    step();
    bus_ack_i = 1'b0;
    checkOutput("both_if_valid", if_valid_o, 1);
    checkOutput("both_if_inst", if_inst_o, 32'hBBBB_CCCC);
    if_req_i = 1'b0;
    step();

    // Randomized transactions checked against the result model
    for (int n = 0; n < 40; n++) begin
      bit                is_data;
      bit                we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [MASK_W-1:0] wmask;
      logic [DATA_W-1:0] rdata;
      logic [DATA_W-1:0] exp;
      int                delay;
      int                gap;
      is_data = 1'($urandom_range(0, 1));
      we      = is_data ? 1'($urandom_range(0, 1)) : 1'b0;
      addr    = $urandom & 32'hFFFF_FFFC;
      wdata   = {$urandom, $urandom};
      wmask   = 8'($urandom);
      rdata   = {$urandom, $urandom};
      delay   = ($urandom_range(0, 9) == 0) ? MAX_WAIT : int'($urandom_range(0, 5));
      if (!is_data)  exp = fetchWord(addr, rdata);
      else if (we)   exp = m_d_rdata;
      else           exp = rdata;
      applyStimulus(is_data, we, addr, wdata, wmask, delay, rdata, exp, m_timeout);
      if (is_data) m_d_rdata = exp;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        step();
        checkOutput("gap_bus_req", bus_req_o, 0);
      end
    end

    // Watchdog: never acknowledge. The read returns zero, the fetch a NOP,
    // and the error flag stays set.
    m_timeout = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h8000_3000, 64'h0, 8'h00, MAX_WAIT + 1, 64'h0, 64'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h8000_0010, 64'h0, 8'h00, MAX_WAIT + 1, 64'h0, 64'h13, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h8000_3008, 64'h0, 8'h00, 0, 64'h1234, 64'h1234, 1'b1);

    // Reset in the middle of a BUSY access
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h8000_4000;
    step();
    step();
    checkOutput("pre_reset_bus_req", bus_req_o, 1);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_bus_req", bus_req_o, 0);
    checkOutput("async_reset_timeout", timeout_o, 0);
    d_req_i = 1'b0;
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput("post_reset_d_valid", d_valid_o, 0);
      checkOutput("post_reset_bus_req", bus_req_o, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
